// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: walks the enabled RTC registers over the multiplexed
// a_d/cs/rd/wr bus and moves each one between the RTC and the register RAM.
// Read mode copies RTC -> RAM, write mode copies RAM -> RTC. Every output
// comes straight from a flop: the next-state logic also computes the value
// each output takes in the following cycle.
module rtc_bus_sequencer #(
    parameter int N_REGS    = 7,
    parameter int IDX_W     = 3,
    parameter int DATA_W    = 8,
    parameter int PHASE_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [N_REGS-1:0] reg_mask,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  reg_idx,
    input  logic [DATA_W-1:0] reg_addr,
    output logic              a_d,
    output logic              cs,
    output logic              rd,
    output logic              wr,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_in,
    output logic [IDX_W-1:0]  ram_idx,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int         PTR_W = IDX_W + 1;
    localparam logic [7:0] LAST  = 8'(PHASE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_ADDR, S_GAP, S_DATA, S_STORE, S_RECOV, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic [N_REGS-1:0]   mask_q, mask_d;
    logic                hit_q, hit_d;
    logic [IDX_W-1:0]    reg_idx_q, reg_idx_d;

    logic                a_d_q, a_d_d;
    logic                cs_q, cs_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   bus_out_q, bus_out_d;
    logic                bus_oe_q, bus_oe_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                ram_we_q, ram_we_d;
    logic                ram_re_q, ram_re_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // The scan runs one cycle ahead: it is evaluated on the edge that enters
    // SCAN, so reg_idx (and hence reg_addr) is already settled when ADDR
    // starts and bus_out carries the right address from the first ADDR cycle.
    logic [N_REGS-1:0]   scan_mask;
    logic [PTR_W-1:0]    scan_ptr;
    logic                scan_hit;
    logic [IDX_W-1:0]    scan_sel;

    assign scan_mask = (state_q == S_IDLE) ? reg_mask : mask_q;
    assign scan_ptr  = (state_q == S_IDLE) ? '0 : (PTR_W'(reg_idx_q) + PTR_W'(1));

    // Lowest enabled register at or above the scan pointer.
    always_comb begin
        scan_hit = 1'b0;
        scan_sel = '0;
        for (int i = N_REGS - 1; i >= 0; i--) begin
            if (scan_mask[i] && (PTR_W'(i) >= scan_ptr)) begin
                scan_hit = 1'b1;
                scan_sel = IDX_W'(i);
            end
        end
    end

    // Next-state sequencing, then the output values for the state being entered.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        mask_d      = mask_q;
        hit_d       = hit_q;
        reg_idx_d   = reg_idx_q;
        bus_out_d   = bus_out_q;
        ram_wdata_d = ram_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    mode_d  = mode;
                    mask_d  = reg_mask;
                    hit_d   = scan_hit;
                    if (scan_hit) reg_idx_d = scan_sel;
                end
            end
            S_SCAN: begin
                state_d = hit_q ? S_ADDR : S_DONE;
            end
            S_ADDR: begin
                if (cnt_q == LAST) state_d = S_GAP;
            end
            S_GAP: begin
                // RAM word requested on the first GAP cycle is valid on the second.
                if (mode_q && (cnt_q == 8'd1)) bus_out_d = ram_rdata;
                if (cnt_q == LAST) state_d = S_DATA;
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    state_d = mode_q ? S_RECOV : S_STORE;
                    if (!mode_q) ram_wdata_d = bus_in;
                end
            end
            S_STORE: begin
                state_d = S_RECOV;
            end
            S_RECOV: begin
                if (cnt_q == LAST) begin
                    state_d = S_SCAN;
                    hit_d   = scan_hit;
                    if (scan_hit) reg_idx_d = scan_sel;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cnt_d = ((state_d == state_q) && (state_q != S_IDLE)) ? (cnt_q + 8'd1) : 8'd0;

        a_d_d    = 1'b1;
        cs_d     = 1'b1;
        rd_d     = 1'b1;
        wr_d     = 1'b1;
        bus_oe_d = 1'b0;
        ram_we_d = 1'b0;
        ram_re_d = 1'b0;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);

        unique case (state_d)
            S_SCAN: begin
                // a_d drops while cs is still high so it never moves with cs.
                a_d_d = ~hit_d;
            end
            S_ADDR: begin
                a_d_d     = 1'b0;
                cs_d      = 1'b0;
                wr_d      = 1'b0;
                bus_oe_d  = 1'b1;
                bus_out_d = reg_addr;
            end
            S_GAP: begin
                ram_re_d = mode_q && (state_q == S_ADDR);
            end
            S_DATA: begin
                cs_d = 1'b0;
                if (mode_q) begin
                    wr_d     = 1'b0;
                    bus_oe_d = 1'b1;
                end else begin
                    rd_d = 1'b0;
                end
            end
            S_STORE: begin
                ram_we_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State and registered outputs; reset returns the bus to idle at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            mode_q      <= 1'b0;
            mask_q      <= '0;
            hit_q       <= 1'b0;
            reg_idx_q   <= '0;
            a_d_q       <= 1'b1;
            cs_q        <= 1'b1;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            bus_out_q   <= '0;
            bus_oe_q    <= 1'b0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            mask_q      <= mask_d;
            hit_q       <= hit_d;
            reg_idx_q   <= reg_idx_d;
            a_d_q       <= a_d_d;
            cs_q        <= cs_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            bus_out_q   <= bus_out_d;
            bus_oe_q    <= bus_oe_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign reg_idx   = reg_idx_q;
    assign ram_idx   = reg_idx_q;
    assign a_d       = a_d_q;
    assign cs        = cs_q;
    assign rd        = rd_q;
    assign wr        = wr_q;
    assign bus_out   = bus_out_q;
    assign bus_oe    = bus_oe_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: one instance at PHASE_CYC=4 with RTC and RAM
// models, one at PHASE_CYC=2 for strobe timing. Expected results come from
// the register mask, the latency formula and the model memories.
`timescale 1ns/1ps
module tb_rtc_bus_sequencer;
    localparam int PA = 4;
    localparam int PB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A (PHASE_CYC = 4) ----------------
    logic       start_a, mode_a;
    logic [6:0] mask_a;
    logic       busy_a, done_a, a_d_a, cs_a, rd_a, wr_a, bus_oe_a, ram_we_a, ram_re_a;
    logic [2:0] reg_idx_a, ram_idx_a;
    logic [7:0] reg_addr_a, bus_out_a, bus_in_a, ram_wdata_a, ram_rdata_a;

    // ---------------- instance B (PHASE_CYC = 2) ----------------
    logic       start_b, mode_b;
    logic [6:0] mask_b;
    logic       busy_b, done_b, a_d_b, cs_b, rd_b, wr_b, bus_oe_b, ram_we_b, ram_re_b;
    logic [2:0] reg_idx_b, ram_idx_b;
    logic [7:0] reg_addr_b, bus_out_b, bus_in_b, ram_wdata_b, ram_rdata_b;

    function automatic logic [7:0] addr_of(input logic [2:0] i);
        return 8'hC0 + {4'd0, i, 1'b0};
    endfunction

    time t0_a = 0;
    time t0_b = 0;

    function automatic int cyc_of(input time t, input time base);
        return int'((t - base) / 10) + 1;
    endfunction

    rtc_bus_sequencer #(.N_REGS(7), .IDX_W(3), .DATA_W(8), .PHASE_CYC(PA)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode_a), .reg_mask(mask_a),
        .busy(busy_a), .done(done_a), .reg_idx(reg_idx_a), .reg_addr(reg_addr_a),
        .a_d(a_d_a), .cs(cs_a), .rd(rd_a), .wr(wr_a), .bus_out(bus_out_a),
        .bus_oe(bus_oe_a), .bus_in(bus_in_a), .ram_idx(ram_idx_a), .ram_wdata(ram_wdata_a),
        .ram_we(ram_we_a), .ram_re(ram_re_a), .ram_rdata(ram_rdata_a)
    );

    rtc_bus_sequencer #(.N_REGS(7), .IDX_W(3), .DATA_W(8), .PHASE_CYC(PB)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode_b), .reg_mask(mask_b),
        .busy(busy_b), .done(done_b), .reg_idx(reg_idx_b), .reg_addr(reg_addr_b),
        .a_d(a_d_b), .cs(cs_b), .rd(rd_b), .wr(wr_b), .bus_out(bus_out_b),
        .bus_oe(bus_oe_b), .bus_in(bus_in_b), .ram_idx(ram_idx_b), .ram_wdata(ram_wdata_b),
        .ram_we(ram_we_b), .ram_re(ram_re_b), .ram_rdata(ram_rdata_b)
    );

    // ---------------- RTC / RAM models for A ----------------
    logic [7:0] rtc_pre [256];
    logic [7:0] ram_pre [8];
    logic [7:0] lat_addr_a;

    assign reg_addr_a = addr_of(reg_idx_a);
    assign bus_in_a   = rtc_pre[lat_addr_a];

    always @(posedge clk) begin
        if (ram_re_a) ram_rdata_a <= ram_pre[ram_idx_a];
    end

    assign reg_addr_b  = addr_of(reg_idx_b);
    assign bus_in_b    = 8'h5A;
    assign ram_rdata_b = 8'h3C;

    // ---------------- bus monitor A ----------------
    logic [17:0] txn_q[$];   // {kind, value, cs-low length}; kind 0=addr 1=read 2=write
    logic [10:0] we_q[$];    // {ram_idx, ram_wdata}
    int   viol_a = 0, done_cnt_a = 0, done_cyc_a = -1, busy_fall_a = -1, re_cnt_a = 0;
    logic prev_busy_a, prev_ad_a, in_win_a, win_ad_a, win_bad_a;
    logic [1:0] win_kind_a;
    logic [7:0] win_val_a, win_len_a;

    assign win_bad_a = !cs_a && ((bus_oe_a !== rd_a) ||
                       (in_win_a ? ((a_d_a !== win_ad_a) || (rd_a && (bus_out_a !== win_val_a)))
                                 : (a_d_a !== prev_ad_a)));

    always @(negedge clk) begin
        if (!reset) begin
            in_win_a    <= 1'b0;
            prev_busy_a <= 1'b0;
            prev_ad_a   <= 1'b1;
            lat_addr_a  <= 8'h00;
        end else begin
            prev_busy_a <= busy_a;
            prev_ad_a   <= a_d_a;
            if (done_a) begin
                done_cnt_a <= done_cnt_a + 1;
                done_cyc_a <= cyc_of($time, t0_a);
            end
            if (prev_busy_a && !busy_a) busy_fall_a <= cyc_of($time, t0_a);
            if (ram_we_a) we_q.push_back({ram_idx_a, ram_wdata_a});
            if (ram_re_a) re_cnt_a <= re_cnt_a + 1;
            viol_a <= viol_a + int'(!rd_a && !wr_a) + int'(win_bad_a);
            if (!cs_a) begin
                if (!a_d_a) lat_addr_a <= bus_out_a;
                in_win_a  <= 1'b1;
                win_len_a <= in_win_a ? win_len_a + 8'd1 : 8'd1;
                if (!in_win_a) begin
                    win_ad_a   <= a_d_a;
                    win_kind_a <= !a_d_a ? 2'd0 : (!rd_a ? 2'd1 : 2'd2);
                end
                win_val_a <= (a_d_a && !rd_a) ? bus_in_a : bus_out_a;
            end else if (in_win_a) begin
                in_win_a <= 1'b0;
                txn_q.push_back({win_kind_a, win_val_a, win_len_a});
            end
        end
    end

    // ---------------- strobe monitor B ----------------
    int   viol_b = 0, done_cnt_b = 0, done_cyc_b = -1, win_cnt_b = 0, win_len_b = 0;
    logic prev_ad_b, in_win_b, win_ad_b, win_bad_b;

    assign win_bad_b = !cs_b && ((bus_oe_b !== rd_b) ||
                       (in_win_b ? (a_d_b !== win_ad_b) : (a_d_b !== prev_ad_b)));

    always @(negedge clk) begin
        if (!reset) begin
            in_win_b  <= 1'b0;
            prev_ad_b <= 1'b1;
        end else begin
            prev_ad_b <= a_d_b;
            if (done_b) begin
                done_cnt_b <= done_cnt_b + 1;
                done_cyc_b <= cyc_of($time, t0_b);
            end
            viol_b <= viol_b + int'(!rd_b && !wr_b) + int'(win_bad_b)
                             + int'(cs_b && in_win_b && (win_len_b != PB));
            if (!cs_b) begin
                in_win_b  <= 1'b1;
                win_len_b <= in_win_b ? win_len_b + 1 : 1;
                if (!in_win_b) win_ad_b <= a_d_b;
            end else if (in_win_b) begin
                in_win_b  <= 1'b0;
                win_cnt_b <= win_cnt_b + 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int txn0, we0, dc0, re0, v0;
    int dcb0, vb0, wb0;

    task automatic snap_a();
        txn0 = txn_q.size();
        we0  = we_q.size();
        dc0  = done_cnt_a;
        re0  = re_cnt_a;
        v0   = viol_a;
    endtask

    task automatic start_seq_a(input logic m, input logic [6:0] mask);
        @(posedge clk); #1;
        start_a = 1'b1; mode_a = m; mask_a = mask;
        @(posedge clk);
        t0_a = $time;
        #1;
        start_a = 1'b0; mode_a = ~m; mask_a = ~mask;
    endtask

    task automatic wait_done_a();
        for (int k = 0; k < 400 && done_cnt_a == dc0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    function automatic int popc(input logic [6:0] v);
        int c = 0;
        for (int j = 0; j < 7; j++) c += int'(v[j]);
        return c;
    endfunction

    task automatic check_a(input logic m, input logic [6:0] mask);
        int n, per, k;
        n   = popc(mask);
        per = 4 * PA + (m ? 1 : 2);
        k   = 0;
        chk("done_pulses", done_cnt_a - dc0, 1);
        chk("done_cycle", done_cyc_a, n * per + 2);
        chk("busy_fall_cycle", busy_fall_a, n * per + 3);
        chk("bus_txn_count", txn_q.size() - txn0, 2 * n);
        chk("protocol_violations", viol_a - v0, 0);
        chk("ram_we_count", we_q.size() - we0, m ? 0 : n);
        chk("ram_re_count", re_cnt_a - re0, m ? n : 0);
        for (int j = 0; j < 7; j++) begin
            if (mask[j]) begin
                if (txn_q.size() >= txn0 + 2 * k + 2) begin
                    chk("addr_phase", txn_q[txn0 + 2 * k], {2'd0, addr_of(3'(j)), 8'(PA)});
                    chk("data_phase", txn_q[txn0 + 2 * k + 1],
                        {(m ? 2'd2 : 2'd1), (m ? ram_pre[j] : rtc_pre[addr_of(3'(j))]), 8'(PA)});
                end
                if (!m && (we_q.size() >= we0 + k + 1))
                    chk("ram_write", we_q[we0 + k], {3'(j), rtc_pre[addr_of(3'(j))]});
                k++;
            end
        end
    endtask

    task automatic run_b(input logic m, input logic [6:0] mask);
        int n;
        n    = popc(mask);
        dcb0 = done_cnt_b;
        vb0  = viol_b;
        wb0  = win_cnt_b;
        @(posedge clk); #1;
        start_b = 1'b1; mode_b = m; mask_b = mask;
        @(posedge clk);
        t0_b = $time;
        #1;
        start_b = 1'b0;
        for (int k = 0; k < 200 && done_cnt_b == dcb0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("b_done_pulses", done_cnt_b - dcb0, 1);
        chk("b_done_cycle", done_cyc_b, n * (4 * PB + (m ? 1 : 2)) + 2);
        chk("b_cs_windows", win_cnt_b - wb0, 2 * n);
        chk("b_strobe_violations", viol_b - vb0, 0);
    endtask

    logic       rm;
    logic [6:0] rmask;

    initial begin
        reset   = 1'b0;
        start_a = 1'b0; mode_a = 1'b0; mask_a = '0;
        start_b = 1'b0; mode_b = 1'b0; mask_b = '0;
        for (int i = 0; i < 256; i++) rtc_pre[i] = 8'h00;
        for (int i = 0; i < 8; i++) ram_pre[i] = 8'h00;
        for (int i = 0; i < 7; i++) rtc_pre[addr_of(3'(i))] = 8'h10 + 8'(i);

        // reset state
        #95;
        chk("rst_strobes", {a_d_a, cs_a, rd_a, wr_a, bus_oe_a, ram_we_a, ram_re_a, busy_a, done_a}, 9'b1111_00000);
        chk("rst_data", {bus_out_a, ram_wdata_a, ram_idx_a, reg_idx_a}, 22'd0);
        #5 reset = 1'b1;
        repeat (2) @(negedge clk);

        // read all registers
        snap_a();
        start_seq_a(1'b0, 7'h7F);
        wait_done_a();
        check_a(1'b0, 7'h7F);
        chk("read_all_done_128", done_cyc_a, 128);
        if (we_q.size() >= we0 + 4) chk("read_all_ram3", we_q[we0 + 3], {3'd3, 8'h13});

        // sparse write
        ram_pre[0] = 8'hA0; ram_pre[2] = 8'hA2; ram_pre[5] = 8'hA5;
        snap_a();
        start_seq_a(1'b1, 7'b0100101);
        wait_done_a();
        check_a(1'b1, 7'b0100101);
        chk("write_sparse_done_53", done_cyc_a, 53);

        // empty mask
        snap_a();
        start_seq_a(1'b0, 7'h00);
        wait_done_a();
        check_a(1'b0, 7'h00);

        // start pulse while busy is ignored
        snap_a();
        start_seq_a(1'b0, 7'h7F);
        for (int k = 0; k < 200 && !(reg_idx_a == 3'd3 && !cs_a); k++) @(negedge clk);
        chk("reached_reg3", {reg_idx_a, cs_a}, {3'd3, 1'b0});
        start_a = 1'b1; mode_a = 1'b1; mask_a = 7'h01;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a();
        check_a(1'b0, 7'h7F);

        // asynchronous reset during a read data phase
        snap_a();
        start_seq_a(1'b0, 7'h7F);
        for (int k = 0; k < 100 && rd_a !== 1'b0; k++) @(negedge clk);
        chk("rd_low_before_reset", rd_a, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_strobes", {rd_a, cs_a, a_d_a, wr_a}, 4'hF);
        chk("rst_mid_busy", {busy_a, bus_oe_a, done_a}, 3'b000);
        @(negedge clk);
        #3 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_idle", {busy_a, cs_a}, 2'b01);
        snap_a();
        start_seq_a(1'b0, 7'h7F);
        wait_done_a();
        check_a(1'b0, 7'h7F);

        // randomized sequences with random memory contents
        for (int it = 0; it < 5; it++) begin
            rm    = 1'($urandom_range(0, 1));
            rmask = 7'($urandom);
            for (int j = 0; j < 7; j++) begin
                rtc_pre[addr_of(3'(j))] = 8'($urandom);
                ram_pre[j]              = 8'($urandom);
            end
            snap_a();
            start_seq_a(rm, rmask);
            wait_done_a();
            check_a(rm, rmask);
        end

        // strobe timing at PHASE_CYC = 2
        run_b(1'b0, 7'h7F);
        run_b(1'b1, 7'h7F);
        for (int it = 0; it < 3; it++) run_b(1'($urandom_range(0, 1)), 7'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Parametrised successor of the single-mode RTC read FSM.
- Walks a configurable set of RTC registers over the multiplexed address/data bus (a_d, cs, rd, wr, all active-low strobes) and moves each register between the RTC and the register-file RAM.
- Supports read mode (RTC->RAM) and write mode (RAM->RTC), a per-register enable mask and programmable strobe width.
- Sits between the top-level controller (start/busy/done handshake) and the RTC pad drivers plus RAM.

Parameters:
- N_REGS, 7, number of RTC registers handled (command, sec, min, hour, day, month, year).
- IDX_W, 3, width of register index; must satisfy 2^IDX_W >= N_REGS.
- DATA_W, 8, RTC bus / RAM data width.
- PHASE_CYC, 4, clock cycles per bus phase; legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- mode  in  1  0 = read RTC into RAM, 1 = write RAM to RTC; latched on start.
- reg_mask  in  N_REGS  bit i set = process register i; latched on start.
- busy  out  1  high from the cycle after start through DONE inclusive.
- done  out  1  one-cycle pulse when the sequence completes.
- reg_idx  out  IDX_W  current register index (drives external address lookup).
- reg_addr  in  DATA_W  RTC address for reg_idx; combinational from reg_idx.
- a_d  out  1  0 = address phase, 1 = data phase; idle high.
- cs  out  1  chip select, active low.
- rd  out  1  read strobe, active low.
- wr  out  1  write strobe, active low.
- bus_out  out  DATA_W  value driven on the RTC bus.
- bus_oe  out  1  bus driver enable.
- bus_in  in  DATA_W  RTC bus sampled value.
- ram_idx  out  IDX_W  RAM word index (= reg_idx).
- ram_wdata  out  DATA_W  data to RAM.
- ram_we  out  1  RAM write enable, one cycle per register (read mode).
- ram_re  out  1  RAM read enable, one cycle per register (write mode).
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_re.

Behaviour:
- Reset (asynchronous, active-low) takes effect immediately, including mid-transfer.
- Reset values: a_d=cs=rd=wr=1, bus_oe=0, bus_out=0, ram_we=ram_re=0, ram_idx=reg_idx=0, ram_wdata=0, busy=0, done=0, state IDLE.
- States: IDLE, SCAN, ADDR, GAP, DATA, STORE, RECOV, DONE. All outputs are registered.
- IDLE:
  - start=1 latches mode and reg_mask, clears the scan pointer, and goes to SCAN.
  - start while busy is ignored.
- SCAN (1 cycle):
  - Priority-selects the lowest set mask bit at index >= pointer and loads reg_idx with it.
  - Next state is ADDR; if no bit remains, DONE.
- ADDR (PHASE_CYC cycles): a_d=0, cs=0, wr=0, bus_oe=1, bus_out=reg_addr.
- GAP (PHASE_CYC cycles):
  - All strobes high, bus_oe=0.
  - Write mode: ram_re=1 on the first GAP cycle; ram_rdata is captured into bus_out on the second GAP cycle.
- DATA (PHASE_CYC cycles): a_d=1, cs=0.
  - Read mode: rd=0, bus_oe=0; bus_in is sampled at the edge ending the last DATA cycle.
  - Write mode: wr=0, bus_oe=1, bus_out holds the RAM word.
- STORE (read mode only, 1 cycle): ram_we=1, ram_idx=reg_idx, ram_wdata=sampled byte.
- RECOV (PHASE_CYC cycles): all strobes high, bus_oe=0. Then pointer = reg_idx+1 and next state is SCAN.
- DONE (1 cycle): done=1, busy=1. Next state is IDLE, where busy=0.
- Latency, with N = popcount(reg_mask) and start sampled at edge 0:
  - done is high in cycle N*(4*PHASE_CYC+2)+2 in read mode.
  - done is high in cycle N*(4*PHASE_CYC+1)+2 in write mode.
- Boundaries:
  - reg_mask=0: SCAN then DONE, done in cycle 2, no strobe activity.
  - Pointer reaching N_REGS: treated as no bit remaining.
  - Mask bits >= N_REGS do not exist.
- cs never falls together with a_d changing: a_d changes only in cycles where cs=1.
- rd and wr are never both low.

Test Plan:
- Read all: reset low 100 ns, mode=0, reg_mask=7'h7F, PHASE_CYC=4, RTC model returns 8'h10+i for address of reg i -> 7 ram_we pulses, RAM[i]=8'h10+i, done in cycle 128, busy falls at cycle 129.
- Write sparse: mode=1, reg_mask=7'b0100101, RAM[0]=8'hA0, RAM[2]=8'hA2, RAM[5]=8'hA5 -> exactly three address/data transactions on indices 0, 2, 5, each with bus_out equal to the RAM word during wr low; done in cycle 3*17+2=53.
- Empty mask: start with reg_mask=0 -> done in cycle 2, cs stays 1 throughout, no ram_we or ram_re.
- Start while busy: pulse start again during register 3 with mode flipped -> ignored; sequence and latched mode unchanged, single done pulse.
- Reset mid-DATA: drive reset low while rd=0 -> same cycle rd=cs=a_d=1 and busy=0; after release, a new start runs a full clean sequence.
- Strobe timing, PHASE_CYC=2: every cs-low window is exactly 2 cycles, a_d stable across each window, and rd/wr never overlap.
